// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds RST_OUT_N low for a fixed time, then waits for the far
// domain's synchronized reset to come back as an acknowledge, or times out.
module rst_seq_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic CLK_M,
  input  logic RST_M,
  input  logic SW_RST_REQ,
  input  logic ACK_IN,
  output logic RST_OUT_N,
  output logic RST_BUSY,
  output logic RST_DONE,
  output logic RST_TIMEOUT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ack_s1, ack_s;
  logic             out_n_nxt, busy_nxt, done_nxt, timeout_nxt;

  // ACK_IN is asynchronous to CLK_M; only ack_s is ever looked at.
  always_ff @(posedge CLK_M) begin
    if (!RST_M) begin
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      ack_s1 <= ACK_IN;
      ack_s  <= ack_s1;
    end
  end

  always_ff @(posedge CLK_M) begin
    if (!RST_M) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      RST_OUT_N   <= 1'b0;
      RST_BUSY    <= 1'b1;
      RST_DONE    <= 1'b0;
      RST_TIMEOUT <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      RST_OUT_N   <= out_n_nxt;
      RST_BUSY    <= busy_nxt;
      RST_DONE    <= done_nxt;
      RST_TIMEOUT <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    out_n_nxt   = RST_OUT_N;
    busy_nxt    = RST_BUSY;
    done_nxt    = 1'b0;
    timeout_nxt = RST_TIMEOUT;
    case (state)
      ST_IDLE: begin
        if (SW_RST_REQ) begin
          state_nxt   = ST_ASSERT;
          cnt_nxt     = '0;
          out_n_nxt   = 1'b0;
          busy_nxt    = 1'b1;
          timeout_nxt = 1'b0;
        end
      end
      ST_ASSERT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
          out_n_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // An acknowledge on the last timeout cycle still wins over the timeout.
        if (ack_s) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_nxt = 1'b1;
          busy_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
        out_n_nxt = 1'b0;
        busy_nxt  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a cycle table on a small-parameter instance plus
// directed multi-cycle sequences on a default-parameter instance.
module tb_rst_seq_ctrl;

  typedef struct {
    logic       rst_m;
    logic       sw;
    logic       ack;
    logic [3:0] exp;
  } vec_t;

  localparam int NVEC = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic rst_d, sw_d, ack_drv, ack_lag, ack_d;
  logic out_n_d, busy_d, done_d, to_d;
  int   ack_mode;

  // corner instance
  logic rst_c, sw_c, ack_c;
  logic out_n_c, busy_c, done_c, to_c;

  int checks = 0;
  int errors = 0;

  int         rise_edge, low_cnt, done_cnt, done_edge, busy_fall, to_edge;
  logic       to_at1;
  logic [3:0] abort_vec;
  vec_t       vecs [NVEC];

  always @(posedge clk) ack_lag <= out_n_d;
  assign ack_d = (ack_mode == 1) ? out_n_d : (ack_mode == 2) ? ack_lag : ack_drv;

  rst_seq_ctrl dut_def (
    .CLK_M(clk), .RST_M(rst_d), .SW_RST_REQ(sw_d), .ACK_IN(ack_d),
    .RST_OUT_N(out_n_d), .RST_BUSY(busy_d), .RST_DONE(done_d), .RST_TIMEOUT(to_d)
  );

  rst_seq_ctrl #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(1), .CNT_W(3)) dut_corner (
    .CLK_M(clk), .RST_M(rst_c), .SW_RST_REQ(sw_c), .ACK_IN(ack_c),
    .RST_OUT_N(out_n_c), .RST_BUSY(busy_c), .RST_DONE(done_c), .RST_TIMEOUT(to_c)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic set_vec(input int i, input logic r, input logic s, input logic a,
                         input logic [3:0] e);
    vecs[i] = '{r, s, a, e};
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Drives the default instance for n edges; SW request at edges sw1/sw2,
  // RST_M low at edge rst_at (0 = never). Edge indices start at 1.
  task automatic apply_stimulus(input int n, input int sw1, input int sw2, input int rst_at);
    logic prev_out, prev_busy;
    prev_out  = out_n_d;
    prev_busy = busy_d;
    rise_edge = -1; low_cnt = 0; done_cnt = 0; done_edge = -1;
    busy_fall = -1; to_edge = -1; to_at1 = 1'bx; abort_vec = 4'bxxxx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      sw_d  = (i == sw1) || (i == sw2);
      rst_d = (i != rst_at);
      @(posedge clk);
      #1;
      if (out_n_d === 1'b0) low_cnt++;
      if (out_n_d === 1'b1 && prev_out === 1'b0 && rise_edge < 0) rise_edge = i;
      if (done_d === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = i;
      end
      if (busy_d === 1'b0 && prev_busy === 1'b1 && busy_fall < 0) busy_fall = i;
      if (to_d === 1'b1 && to_edge < 0) to_edge = i;
      if (i == 1) to_at1 = to_d;
      if (i == rst_at) abort_vec = {out_n_d, busy_d, done_d, to_d};
      prev_out  = out_n_d;
      prev_busy = busy_d;
    end
    @(negedge clk);
    sw_d  = 1'b0;
    rst_d = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_d = 1'b0; sw_d = 1'b0; ack_drv = 1'b0; ack_mode = 0;
    rst_c = 1'b0; sw_c = 1'b0; ack_c = 1'b0;

    // {RST_OUT_N, RST_BUSY, RST_DONE, RST_TIMEOUT} after each edge, H=4 T=1
    set_vec( 0, 0, 0, 0, 4'b0100); set_vec( 1, 0, 0, 0, 4'b0100);
    set_vec( 2, 1, 0, 0, 4'b0100); set_vec( 3, 1, 0, 0, 4'b0100);
    set_vec( 4, 1, 0, 0, 4'b0100); set_vec( 5, 1, 0, 0, 4'b1100);
    set_vec( 6, 1, 0, 0, 4'b1001); set_vec( 7, 1, 0, 0, 4'b1001);
    set_vec( 8, 1, 1, 0, 4'b0100); set_vec( 9, 1, 0, 1, 4'b0100);
    set_vec(10, 1, 0, 1, 4'b0100); set_vec(11, 1, 0, 1, 4'b0100);
    set_vec(12, 1, 0, 1, 4'b1100); set_vec(13, 1, 0, 1, 4'b1010);
    set_vec(14, 1, 0, 1, 4'b1000); set_vec(15, 1, 1, 1, 4'b0100);
    set_vec(16, 1, 1, 1, 4'b0100); set_vec(17, 1, 0, 1, 4'b0100);
    set_vec(18, 1, 0, 1, 4'b0100); set_vec(19, 1, 0, 1, 4'b1100);
    set_vec(20, 1, 1, 1, 4'b1010); set_vec(21, 1, 1, 1, 4'b0100);
    set_vec(22, 1, 0, 0, 4'b0100); set_vec(23, 1, 0, 0, 4'b0100);
    set_vec(24, 1, 0, 0, 4'b0100); set_vec(25, 1, 0, 0, 4'b1100);
    set_vec(26, 1, 0, 0, 4'b1001); set_vec(27, 0, 0, 0, 4'b0100);
    set_vec(28, 1, 0, 0, 4'b0100); set_vec(29, 1, 0, 0, 4'b0100);
    set_vec(30, 1, 0, 0, 4'b0100); set_vec(31, 1, 0, 0, 4'b1100);
    set_vec(32, 0, 0, 0, 4'b0100); set_vec(33, 1, 0, 0, 4'b0100);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst_c = vecs[i].rst_m;
      sw_c  = vecs[i].sw;
      ack_c = vecs[i].ack;
      @(posedge clk);
      #1;
      check_output($sformatf("corner_vec%0d", i),
                   {28'd0, out_n_c, busy_c, done_c, to_c}, {28'd0, vecs[i].exp});
    end

    // Power-on with ACK_IN tied to RST_OUT_N
    ack_mode = 1;
    @(negedge clk); rst_d = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_output("reset_state", {28'd0, out_n_d, busy_d, done_d, to_d}, 32'b0100);
    apply_stimulus(40, 0, 0, 0);
    check_output("por_rise_edge", rise_edge, 16);
    check_output("por_low_cnt", low_cnt, 15);
    check_output("por_done_cnt", done_cnt, 1);
    check_output("por_done_edge", done_edge, 19);
    check_output("por_busy_fall", busy_fall, 19);

    // SW request, ACK_IN following RST_OUT_N one cycle later
    ack_mode = 2;
    apply_stimulus(30, 1, 0, 0);
    check_output("sw_rise_edge", rise_edge, 17);
    check_output("sw_low_cnt", low_cnt, 16);
    check_output("sw_done_edge", done_edge, 21);
    check_output("sw_done_cnt", done_cnt, 1);
    check_output("sw_busy_fall", busy_fall, 21);

    // Timeout with ACK_IN held low
    ack_mode = 0; ack_drv = 1'b0;
    apply_stimulus(90, 1, 0, 0);
    check_output("to_edge", to_edge, 81);
    check_output("to_busy_fall", busy_fall, 81);
    check_output("to_done_cnt", done_cnt, 0);
    check_output("to_sticky", {31'd0, to_d}, 1);

    // Stale acknowledge held high; this request also clears the timeout flag
    ack_drv = 1'b1;
    for (int i = 0; i < 3; i++) step();
    apply_stimulus(25, 1, 0, 0);
    check_output("stale_to_cleared", {31'd0, to_at1}, 0);
    check_output("stale_rise_edge", rise_edge, 17);
    check_output("stale_low_cnt", low_cnt, 16);
    check_output("stale_done_edge", done_edge, 18);
    check_output("stale_done_cnt", done_cnt, 1);

    // Request pulsed again at hold cycle 5 is ignored
    apply_stimulus(40, 1, 6, 0);
    check_output("busy_rise_edge", rise_edge, 17);
    check_output("busy_low_cnt", low_cnt, 16);
    check_output("busy_done_cnt", done_cnt, 1);
    check_output("busy_done_edge", done_edge, 18);
    check_output("busy_busy_fall", busy_fall, 18);

    // RST_M pulled low on the edge where RST_DONE would fire
    apply_stimulus(24, 1, 0, 18);
    check_output("abort_outputs", {28'd0, abort_vec}, 32'b0100);
    check_output("abort_done_cnt", done_cnt, 0);
    check_output("abort_low_cnt", low_cnt, 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
